// File: rtl/ibex_xif_pkg.sv
// Shared icache geometry plus helpers for the icache RAM responder model.
package ibex_xif_pkg;

    localparam int unsigned IC_NUM_WAYS   = 2;
    localparam int unsigned IC_INDEX_W    = 8;
    localparam int unsigned IC_TAG_SIZE   = 22;
    localparam int unsigned IC_LINE_BEATS = 2;
    localparam int unsigned BUS_SIZE      = 32;

    // Fibonacci taps 16,14,13,11 expressed as state bit positions 15,13,12,10
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;

    typedef enum logic {
        IC_RAM_RD = 1'b0,
        IC_RAM_WR = 1'b1
    } ic_ram_op_e;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR16_TAPS)};
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/ibex_xif_icache_ram_bank.sv
// Single-way RAM bank: unreset storage, per-entry written bits, one-cycle registered read.
module ibex_xif_icache_ram_bank #(
    parameter int unsigned Width = 32,
    parameter int unsigned AddrW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             write_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << AddrW;

    logic [Width-1:0] mem_q [Depth];
    logic [Depth-1:0] written_q, written_d;
    logic             rvalid_q, rvalid_d;
    logic [Width-1:0] rdata_q, rdata_d;

    always_comb begin
        written_d = written_q;
        rvalid_d  = req_i & ~write_i;
        rdata_d   = rdata_q;
        if (req_i && write_i) begin
            written_d[addr_i] = 1'b1;
        end
        // Unwritten entries read as zero so stale power-up contents never leak out
        if (req_i && !write_i) begin
            rdata_d = written_q[addr_i] ? mem_q[addr_i] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_i && write_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            written_q <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            written_q <= written_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/ibex_xif_icache_ram_responder.sv
// RAM end of the icache RAM interface: tag/data banks, LFSR grant stalls, traffic counters, protocol checker.
module ibex_xif_icache_ram_responder
    import ibex_xif_pkg::*;
#(
    parameter int unsigned TagSizeECC  = IC_TAG_SIZE,
    parameter int unsigned LineSizeECC = IC_LINE_BEATS * BUS_SIZE,
    parameter int unsigned StallThresh = 32,
    parameter int unsigned MaxStall    = 4,
    parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_en_i,
    input  logic [IC_NUM_WAYS-1:0] ic_tag_req_i,
    input  logic                   ic_tag_write_i,
    input  logic [IC_INDEX_W-1:0]  ic_tag_addr_i,
    input  logic [TagSizeECC-1:0]  ic_tag_wdata_i,
    output logic [IC_NUM_WAYS-1:0] ic_tag_rvalid_o,
    output logic [TagSizeECC-1:0]  ic_tag_rdata_o [IC_NUM_WAYS],
    input  logic [IC_NUM_WAYS-1:0] ic_data_req_i,
    output logic [IC_NUM_WAYS-1:0] ic_data_gnt_o,
    input  logic                   ic_data_write_i,
    input  logic [IC_INDEX_W-1:0]  ic_data_addr_i,
    input  logic [LineSizeECC-1:0] ic_data_wdata_i,
    output logic [IC_NUM_WAYS-1:0] ic_data_rvalid_o,
    output logic [LineSizeECC-1:0] ic_data_rdata_o [IC_NUM_WAYS],
    output logic [31:0]            rd_count_o,
    output logic [31:0]            wr_count_o,
    output logic                   proto_err_o
);

    ic_ram_op_e tag_op, data_op;
    logic [IC_NUM_WAYS-1:0] data_gnt;
    logic                   stall, tag_xfer, data_xfer, proto_violation, addr_unknown;
    logic [1:0]             rd_inc, wr_inc;

    logic [15:0]            lfsr_q, lfsr_d;
    logic [7:0]             stall_cnt_q, stall_cnt_d;
    logic                   stall_q, stall_d;
    logic [IC_NUM_WAYS-1:0] req_q, req_d;
    logic                   write_q, write_d;
    logic [IC_INDEX_W-1:0]  addr_q, addr_d;
    logic [LineSizeECC-1:0] wdata_q, wdata_d;
    logic                   proto_err_q, proto_err_d;
    logic [31:0]            rd_count_q, rd_count_d, wr_count_q, wr_count_d;

    always_comb begin
        tag_op  = ic_tag_write_i  ? IC_RAM_WR : IC_RAM_RD;
        data_op = ic_data_write_i ? IC_RAM_WR : IC_RAM_RD;

        // One stall decision covers every requesting way so ways never split
        stall = stall_en_i & (|ic_data_req_i)
              & ({25'b0, lfsr_q[6:0]} < StallThresh)
              & ({24'b0, stall_cnt_q} < MaxStall);
        data_gnt    = ic_data_req_i & {IC_NUM_WAYS{~stall}};
        lfsr_d      = (|ic_data_req_i) ? lfsr16_next(lfsr_q) : lfsr_q;
        stall_cnt_d = stall ? stall_cnt_q + 8'd1 : 8'd0;
        stall_d     = stall;

        req_d   = ic_data_req_i;
        write_d = ic_data_write_i;
        addr_d  = ic_data_addr_i;
        wdata_d = ic_data_wdata_i;

        proto_violation = stall_q & ((ic_data_req_i != req_q) | (ic_data_write_i != write_q)
                        | (ic_data_addr_i != addr_q) | (ic_data_wdata_i != wdata_q));
        addr_unknown = 1'b0;
`ifndef SYNTHESIS
        if (((|ic_tag_req_i) && $isunknown(ic_tag_addr_i)) ||
            ((|ic_data_req_i) && $isunknown(ic_data_addr_i))) begin
            addr_unknown = 1'b1;
        end
`endif
        proto_err_d = proto_err_q | proto_violation | addr_unknown;

        tag_xfer   = |ic_tag_req_i;
        data_xfer  = |data_gnt;
        rd_inc     = {1'b0, tag_xfer & (tag_op == IC_RAM_RD)} + {1'b0, data_xfer & (data_op == IC_RAM_RD)};
        wr_inc     = {1'b0, tag_xfer & (tag_op == IC_RAM_WR)} + {1'b0, data_xfer & (data_op == IC_RAM_WR)};
        rd_count_d = sat_add32(rd_count_q, rd_inc);
        wr_count_d = sat_add32(wr_count_q, wr_inc);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q      <= LfsrSeed;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
            req_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            proto_err_q <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
            req_q       <= req_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
        end
    end

    for (genvar w = 0; w < IC_NUM_WAYS; w++) begin : g_way
        ibex_xif_icache_ram_bank #(
            .Width (TagSizeECC),
            .AddrW (IC_INDEX_W)
        ) u_tag_bank (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .req_i    (ic_tag_req_i[w]),
            .write_i  (tag_op == IC_RAM_WR),
            .addr_i   (ic_tag_addr_i),
            .wdata_i  (ic_tag_wdata_i),
            .rvalid_o (ic_tag_rvalid_o[w]),
            .rdata_o  (ic_tag_rdata_o[w])
        );

        ibex_xif_icache_ram_bank #(
            .Width (LineSizeECC),
            .AddrW (IC_INDEX_W)
        ) u_data_bank (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .req_i    (data_gnt[w]),
            .write_i  (data_op == IC_RAM_WR),
            .addr_i   (ic_data_addr_i),
            .wdata_i  (ic_data_wdata_i),
            .rvalid_o (ic_data_rvalid_o[w]),
            .rdata_o  (ic_data_rdata_o[w])
        );
    end

    assign ic_data_gnt_o = data_gnt;
    assign rd_count_o    = rd_count_q;
    assign wr_count_o    = wr_count_q;
    assign proto_err_o   = proto_err_q;

endmodule
